// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and instruction-fetch stage.
// The fetch engine alternates between FETCH (request the word at pc and wait for
// ack) and HOLD (present the instruction until the datapath retires it). On
// retirement it advances pc to the sequential, branch or jump target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic [31:0] instr_count_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] branch_off_d;
  logic [31:0] jump_target_d;
  logic        branch_taken_d;
  logic [31:0] next_pc_d;

  // Memory request is decoded straight from the state so it drops the same
  // cycle the instruction is captured; the address is always the current pc.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_count = instr_count_q;

  // Next-PC selection: jump beats any branch; an illegal eq+ne decode simply
  // takes the branch since one of the two conditions is always true.
  always_comb begin
    pc_plus4_d     = pc_q + 32'd4;
    branch_off_d   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jump_target_d  = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
    branch_taken_d = (branch_eq & zero) | (branch_ne & ~zero);
    next_pc_d      = pc_plus4_d;
    if (jump) begin
      next_pc_d = jump_target_d;
    end else if (branch_taken_d) begin
      next_pc_d = pc_plus4_d + branch_off_d;
    end
  end

  // Fetch/hold state machine with all architectural state registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // pc is left untouched here so the address stays stable across wait states.
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (exec_done) begin
            pc_q          <= {next_pc_d[31:2], 2'b00};
            instr_valid_q <= 1'b0;
            instr_count_q <= instr_count_q + 32'd1;
            state_q       <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, sequential fetch, branches,
// jump priority, wait states, ignored inputs and reset during a pending fetch.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;
  logic        zero;
  logic [31:0] instr_count;

  int checks;
  int failures;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .exec_done  (exec_done),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .jump       (jump),
    .zero       (zero),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch of word w at the current address, then retire it with the
  // given control inputs and check the resulting fetch address and count.
  task automatic run_instr(input string tag, input logic [31:0] w,
                           input logic j, input logic beq, input logic bne,
                           input logic z, input logic [31:0] exp_next,
                           input logic [31:0] exp_cnt);
    logic [31:0] here;
    here       = imem_addr;
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_pc"}, pc_out, here);
    exec_done = 1'b1;
    jump      = j;
    branch_eq = beq;
    branch_ne = bne;
    zero      = z;
    step();
    exec_done = 1'b0;
    jump      = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    chk({tag, "_next"}, imem_addr, exp_next);
    chk({tag, "_cnt"}, instr_count, exp_cnt);
    $display("txn %s: instr=%h at %h -> next %h count %0d", tag, w, here, imem_addr, instr_count);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    exec_done  = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;

    // Reset held for 3 cycles.
    step(); step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc_out, RPC);
    rst = 1'b0;
    step();
    chk("fetch0_req", {31'd0, imem_req}, 32'd1);
    chk("fetch0_addr", imem_addr, RPC);
    chk("fetch0_valid", {31'd0, instr_valid}, 32'd0);
    chk("fetch0_count", instr_count, 32'd0);
    $display("txn reset: req=%b addr=%h", imem_req, imem_addr);

    // Sequential add, zero-wait ack; check the HOLD view explicitly first.
    imem_ack   = 1'b1;
    imem_rdata = 32'h012A_4020;
    step();
    imem_ack   = 1'b0;
    chk("add_valid", {31'd0, instr_valid}, 32'd1);
    chk("add_req", {31'd0, imem_req}, 32'd0);
    chk("add_instr", instr, 32'h012A_4020);
    chk("add_pc", pc_out, RPC);
    chk("add_op", {26'd0, instr[31:26]}, 32'd0);
    chk("add_pc4", pc_plus4, 32'h0040_0004);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("add_next", imem_addr, 32'h0040_0004);
    chk("add_cnt", instr_count, 32'd1);
    chk("add_validclr", {31'd0, instr_valid}, 32'd0);
    $display("txn add: next %h count %0d", imem_addr, instr_count);

    run_instr("nop0",     32'h0000_0000, 0, 0, 0, 0, 32'h0040_0008, 32'd2);
    run_instr("beq_t",    32'h1109_0003, 0, 1, 0, 1, 32'h0040_0018, 32'd3);
    run_instr("j_back",   32'h0810_0002, 1, 0, 0, 0, 32'h0040_0008, 32'd4);
    run_instr("beq_nt",   32'h1109_0003, 0, 1, 0, 0, 32'h0040_000C, 32'd5);
    run_instr("nop1",     32'h0000_0000, 0, 0, 0, 0, 32'h0040_0010, 32'd6);
    run_instr("bne_self", 32'h1509_FFFF, 0, 0, 1, 0, 32'h0040_0010, 32'd7);
    run_instr("bne_nt",   32'h1509_FFFF, 0, 0, 1, 1, 32'h0040_0014, 32'd8);
    run_instr("nop2",     32'h0000_0000, 0, 0, 0, 0, 32'h0040_0018, 32'd9);
    run_instr("nop3",     32'h0000_0000, 0, 0, 0, 0, 32'h0040_001C, 32'd10);
    run_instr("nop4",     32'h0000_0000, 0, 0, 0, 0, 32'h0040_0020, 32'd11);
    run_instr("j_prio",   32'h0810_0000, 1, 1, 0, 1, 32'h0040_0000, 32'd12);
    run_instr("eqne",     32'h1109_0003, 0, 1, 1, 0, 32'h0040_0010, 32'd13);

    // Wait states at 0x0040_0010; exec_done in FETCH must be ignored.
    exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0040_0010);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_cnt", instr_count, 32'd13);
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("wait_ackvalid", {31'd0, instr_valid}, 32'd1);
    chk("wait_ackinstr", instr, 32'hDEAD_BEEF);
    $display("txn wait: instr=%h after 3 wait cycles", instr);

    // Stray ack in HOLD must not overwrite the held instruction.
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("hold_instr", instr, 32'hDEAD_BEEF);
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("hold_next", imem_addr, 32'h0040_0014);
    chk("hold_cnt", instr_count, 32'd14);
    $display("txn hold: next %h count %0d", imem_addr, instr_count);

    // Reset during a pending fetch.
    step();
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    step();
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_cnt", instr_count, 32'd0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, RPC);
    $display("txn midreset: refetch addr %h", imem_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and instruction-fetch stage for the MIPS processor. It sits directly upstream of the control decoder and feeds it the opcode field of the held instruction. It consumes the decoder's branch_eq, branch_ne and jump outputs, plus the ALU zero flag, to select the next PC. Instruction memory is accessed over a req/ack handshake with wait states, and each instruction is held stable until the datapath signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; always equals pc.
imem_ack  input  1  memory has imem_rdata valid this cycle; meaningful only while imem_req=1.
imem_rdata  input  32  instruction word.
instr  output  32  held instruction; instr[31:26] drives the control decoder opcode input.
instr_valid  output  1  instr holds a fetched instruction awaiting execution.
pc_out  output  32  address of the held instruction.
pc_plus4  output  32  pc_out+4, modulo 2^32.
exec_done  input  1  datapath has finished the held instruction; next PC is committed.
branch_eq  input  1  from the control decoder.
branch_ne  input  1  from the control decoder.
jump  input  1  from the control decoder.
zero  input  1  ALU zero flag for the held instruction.
instr_count  output  32  count of retired instructions; wraps modulo 2^32.

Behaviour:
- States are RESET, FETCH and HOLD.
- Reset, on any edge with rst=1, regardless of state:
  - state<=RESET, pc<=RESET_PC, instr<=0, instr_valid<=0, instr_count<=0.
  - imem_req is 0 in RESET.
- RESET -> FETCH on the first edge with rst=0.
- FETCH:
  - imem_req=1 (combinational from state); imem_addr=pc.
  - pc is stable while imem_req=1.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, state<=HOLD.
  - With imem_ack=0 the block stays in FETCH with req held; there is no timeout.
  - A zero-wait memory (ack in the first FETCH cycle) gives instr_valid=1 one cycle after req rises.
- HOLD:
  - imem_req=0; instr, pc_out and instr_valid are stable.
  - On an edge with exec_done=1: pc<=next_pc, instr_valid<=0, instr_count<=instr_count+1, state<=FETCH.
  - Minimum throughput is 2 cycles per instruction.
- next_pc, combinational, evaluated in HOLD, in priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump overrides any branch.
  - (branch_eq & zero) | (branch_ne & ~zero): pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit modulo add.
  - Otherwise: pc_plus4.
- If branch_eq and branch_ne are both 1 (illegal decode), the branch is taken; no error is flagged.
- Ignored inputs:
  - exec_done outside HOLD.
  - imem_ack outside FETCH.
- Memory contract: ack is asserted only in cycles where req=1. A fetch abandoned by reset is not completed. Memory must not present a late ack after the req drop.
- Wrap-around: pc 0xFFFF_FFFC with a sequential next gives 0x0000_0000.
- pc[1:0] is always 00.
- Outputs are registered, except imem_req, imem_addr and pc_plus4, which derive combinationally from state/pc.

Test Plan:
- Reset, RESET_PC=0x0040_0000: hold rst 3 cycles, then release -> first cycle after release: imem_req=1, imem_addr=0x0040_0000; instr_valid=0, instr_count=0.
- Sequential fetch: zero-wait ack with rdata 0x012A_4020 (add), exec_done=1 with all control inputs 0 -> instr=0x012A_4020 and pc_out=0x0040_0000 in HOLD, next imem_addr=0x0040_0004, instr_count=1.
- beq: instr 0x1109_0003 at 0x0040_0008, branch_eq=1, zero=1 -> next addr 0x0040_0018. Repeat with zero=0 -> 0x0040_000C.
- bne backward: instr 0x1509_FFFF at 0x0040_0010, branch_ne=1, zero=0 -> next addr 0x0040_0010 (self-loop).
- Jump priority: instr 0x0810_0000 at 0x0040_0020, jump=1, branch_eq=1, zero=1 -> next addr 0x0040_0000.
- Wait states and reset: ack delayed 3 cycles -> req and addr held stable, instr_valid=0 until the ack edge. Assert rst mid-wait -> req=0 the next cycle, instr_count=0; after release, refetch from RESET_PC.
